// File: rtl/demux_stream_1xn_if.sv
// -----------------------------------------------------------------------------
// demux_stream_1xn_if
// Stream bundle between one producer, the 1-to-N demux and N consumers.
//
// Handshake (both sides): a word moves on a rising edge where valid and ready
// are both high. A source that raises valid holds valid and data until that
// edge. ready may be computed from the sink's state, but never from valid.
//
// Signals:
//   i_valid/i_ready/i_data/i_sel : producer -> demux input stream
//   i_bcast                      : broadcast request (only with DEMUX_BCAST_EN)
//   o_valid/o_ready/o_data       : demux -> N consumers, channel k at
//                                  o_data[k*DW +: DW]
// Modports:
//   slave  : the demux side
//   master : the environment side (producer and consumers)
// Optional feature macro: DEMUX_BCAST_EN
// -----------------------------------------------------------------------------
interface demux_stream_1xn_if #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic            i_valid;
    logic            i_ready;
    logic [DW-1:0]   i_data;
    logic [SW-1:0]   i_sel;
`ifdef DEMUX_BCAST_EN
    logic            i_bcast;
`endif
    logic [N-1:0]    o_valid;
    logic [N-1:0]    o_ready;
    logic [N*DW-1:0] o_data;

`ifdef DEMUX_BCAST_EN
    modport slave  (input  i_valid, i_data, i_sel, i_bcast, o_ready,
                    output i_ready, o_valid, o_data);
    modport master (output i_valid, i_data, i_sel, i_bcast, o_ready,
                    input  i_ready, o_valid, o_data);
`else
    modport slave  (input  i_valid, i_data, i_sel, o_ready,
                    output i_ready, o_valid, o_data);
    modport master (output i_valid, i_data, i_sel, o_ready,
                    input  i_ready, o_valid, o_data);
`endif
endinterface

// File: rtl/demux_stream_1xn.sv
// -----------------------------------------------------------------------------
// demux_stream_1xn
// Registered 1-to-N stream demultiplexer. Each accepted input word is routed
// to the channel chosen by i_sel and held in that channel's one-entry
// register until its consumer takes it. Out-of-range selects are accepted,
// dropped, flagged on err one cycle later and counted in drop_cnt.
//
// Parameters: DW data width, N channels (2..16), SW select width (N <= 2**SW)
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : demux_stream_1xn_if.slave (input stream + N output streams)
//   err        : one-cycle pulse per dropped word
//   drop_cnt   : saturating (255) count of dropped words
//   dbg_state  : per-channel FSM state, bit k = 1 when channel k is FULL
// Optional feature macro: DEMUX_BCAST_EN adds bus.i_bcast; a broadcast word
// waits until every channel can take it, then loads all channels at once.
// -----------------------------------------------------------------------------
module demux_stream_1xn #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    demux_stream_1xn_if.slave        bus,
    output logic                     err,
    output logic [7:0]               drop_cnt,
    output logic [N-1:0]             dbg_state
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    ch_state_t     state_q [N];
    ch_state_t     state_d [N];
    logic [DW-1:0] data_q  [N];
    logic [DW-1:0] data_d  [N];
    logic          err_q,      err_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic [N-1:0]  can_take;
    logic          sel_in_range;
    logic          sel_take;
    logic          bcast;
    logic          accept;

    // Extra bit keeps the range compare correct when N == 2**SW.
    assign sel_in_range = ({1'b0, bus.i_sel} < (SW+1)'(N));

`ifdef DEMUX_BCAST_EN
    assign bcast = bus.i_bcast;
`else
    assign bcast = 1'b0;
`endif

    // A channel can take a word when empty, or when full and draining now.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            can_take[k] = (state_q[k] == EMPTY) || bus.o_ready[k];
        end
    end

    // Out-of-range selects look ready so the dropped word never stalls.
    always_comb begin
        sel_take = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (bus.i_sel == SW'(k)) begin
                sel_take = can_take[k];
            end
        end
    end

    always_comb begin
        if (bcast) begin
            bus.i_ready = &can_take;
        end else begin
            bus.i_ready = sel_take;
        end
    end

    assign accept = bus.i_valid && bus.i_ready;

    // Next-state: load wins over drain, which gives drain-and-refill with no
    // bubble; a drain alone empties the channel but keeps the data register.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (accept && (bcast || (sel_in_range && (bus.i_sel == SW'(k))))) begin
                state_d[k] = FULL;
                data_d[k]  = bus.i_data;
            end else if ((state_q[k] == FULL) && bus.o_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    always_comb begin
        err_d      = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (accept && !bcast && !sel_in_range) begin
            err_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
            err_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            for (int k = 0; k < N; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            bus.o_valid[k]            = (state_q[k] == FULL);
            dbg_state[k]              = (state_q[k] == FULL);
            bus.o_data[k*DW +: DW]    = data_q[k];
        end
    end

    assign err      = err_q;
    assign drop_cnt = drop_cnt_q;

endmodule
